csr_trap_ctrl: RTL and testbench

Machine-mode CSR and trap controller for the RV32I core. It owns the writable machine CSRs (mstatus, mie, mscratch, mepc, mcause) and serves CSRRW/CSRRS/CSRRC accesses from the execute stage. It sequences trap entry for exceptions and the timer, external and software interrupts, and sequences MRET return. It sits beside the execute stage and drives the fetch redirect.

---
 rtl/csr_trap_ctrl.sv | 173 +++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap sequencer: serves CSRRW/RS/RC, takes exceptions and
// interrupts at instruction boundaries, and sequences MRET with a fetch redirect.
module csr_trap_ctrl #(
  parameter int          XLEN       = 32,
  parameter logic [29:0] MTVEC_BASE = 30'h0000_0010
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_csr_valid,
  input  logic [1:0]      i_csr_op,
  input  logic [11:0]     i_csr_addr,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic            o_csr_ready,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_illegal_csr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_instr_retire,
  input  logic            i_exc_valid,
  input  logic [3:0]      i_exc_cause,
  input  logic            i_mret,
  input  logic            i_mtimer_intr,
  input  logic            i_mextern_intr,
  input  logic            i_msoftware_intr,
  output logic            o_busy,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_trap_taken,
  output logic [XLEN-1:0] o_mstatus,
  output logic [XLEN-1:0] o_mie,
  output logic [XLEN-1:0] o_mip,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_mcause,
  output logic [XLEN-1:0] o_mscratch
);

  typedef enum logic [2:0] {IDLE, CSR_ACC, TRAP_SAVE, TRAP_JUMP, MRET_JUMP} state_t;

  localparam logic [XLEN-1:0] MISA     = 32'h4000_0100;
  localparam logic [XLEN-1:0] MTVEC    = {MTVEC_BASE, 2'b00};
  localparam logic [XLEN-1:0] IRQ_MASK = 32'h0000_0888;
  localparam logic [XLEN-1:0] MCAUSE_M = 32'h8000_000F;
  localparam logic [XLEN-1:0] EPC_MASK = 32'hFFFF_FFFC;

  state_t            state, next;
  logic              busy_q;
  logic              st_mie, st_mpie;
  logic [XLEN-1:0]   mie_q, mip_q, mscratch_q, mepc_q, mcause_q;
  logic [1:0]        op_q;
  logic [11:0]       addr_q;
  logic [XLEN-1:0]   wdata_q, pc_q, cause_q;
  logic [XLEN-1:0]   mstatus, pend, rd_val, wval, cause_d;
  logic [3:0]        irq_code;
  logic              irq_take, known, ro, illegal, do_write;

  assign mstatus  = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign pend     = mip_q & mie_q & IRQ_MASK;
  assign irq_take = st_mie & i_instr_retire & (|pend);
  // external > software > timer
  assign irq_code = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);
  assign cause_d  = i_exc_valid ? {1'b0, 27'b0, i_exc_cause} : {1'b1, 27'b0, irq_code};

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (i_exc_valid || irq_take)           next = TRAP_SAVE;
        else if (i_mret)                       next = MRET_JUMP;
        else if (i_csr_valid && i_csr_op != 2'b00) next = CSR_ACC;
      end
      CSR_ACC:   next = IDLE;
      TRAP_SAVE: next = TRAP_JUMP;
      TRAP_JUMP: next = IDLE;
      MRET_JUMP: next = IDLE;
      default:   next = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    known  = 1'b1;
    ro     = 1'b0;
    case (addr_q)
      12'h300: rd_val = mstatus;
      12'h301: begin rd_val = MISA;  ro = 1'b1; end
      12'h304: rd_val = mie_q;
      12'h305: begin rd_val = MTVEC; ro = 1'b1; end
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h344: begin rd_val = mip_q; ro = 1'b1; end
      12'hF14: ro = 1'b1;
      default: known = 1'b0;
    endcase
  end

  // RS/RC with a zero operand to a read-only CSR is a legal pure read
  assign illegal  = !known || (ro && (op_q == 2'b01 || wdata_q != '0));
  assign wval     = (op_q == 2'b01) ? wdata_q :
                    (op_q == 2'b10) ? (rd_val | wdata_q) : (rd_val & ~wdata_q);
  assign do_write = (state == CSR_ACC) && !illegal && !ro;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state  <= next;
      busy_q <= (next != IDLE);
      if (state == IDLE) begin
        op_q    <= i_csr_op;
        addr_q  <= i_csr_addr;
        wdata_q <= i_csr_wdata;
        pc_q    <= i_pc;
        cause_q <= cause_d;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mip_q <= {20'b0, i_mextern_intr, 3'b0, i_mtimer_intr, 3'b0, i_msoftware_intr, 3'b0};
      if (do_write) begin
        case (addr_q)
          12'h300: begin st_mie <= wval[3]; st_mpie <= wval[7]; end
          12'h304: mie_q      <= wval & IRQ_MASK;
          12'h340: mscratch_q <= wval;
          12'h341: mepc_q     <= wval & EPC_MASK;
          12'h342: mcause_q   <= wval & MCAUSE_M;
          default: ;
        endcase
      end
      if (state == TRAP_SAVE) begin
        mepc_q   <= pc_q & EPC_MASK;
        mcause_q <= cause_q;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end
      if (state == MRET_JUMP) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
    end
  end

  assign o_busy        = busy_q;
  assign o_csr_ready   = (state == CSR_ACC);
  assign o_csr_rdata   = o_csr_ready ? rd_val : '0;
  assign o_illegal_csr = o_csr_ready && illegal;
  assign o_trap_taken  = (state == TRAP_JUMP);
  assign o_redirect    = (state == TRAP_JUMP) || (state == MRET_JUMP);
  assign o_redirect_pc = (state == TRAP_JUMP) ? MTVEC :
                         (state == MRET_JUMP) ? mepc_q : '0;
  assign o_mstatus     = mstatus;
  assign o_mie         = mie_q;
  assign o_mip         = mip_q;
  assign o_mepc        = mepc_q;
  assign o_mcause      = mcause_q;
  assign o_mscratch    = mscratch_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scenario bench for csr_trap_ctrl: CSR results and redirects are queued when driven
// and checked when the DUT acknowledges them.
module tb_csr_trap_ctrl;

  typedef struct packed { logic ill; logic [31:0] rdata; } csr_exp_t;
  typedef struct packed { logic trap; logic [31:0] pc; } rd_exp_t;

  logic        clk, rst_n;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_ready, illegal;
  logic [31:0] pc;
  logic        retire, exc_valid, mret;
  logic [3:0]  exc_cause;
  logic        timer, ext, sw;
  logic        busy, redirect, trap_taken;
  logic [31:0] redirect_pc, mstatus, mie, mip, mepc, mcause, mscratch;

  int checks = 0;
  int failures = 0;
  csr_exp_t csr_q[$];
  rd_exp_t  rd_q[$];

  localparam logic [31:0] MTVEC = 32'h0000_0040;

  csr_trap_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_csr_valid(csr_valid), .i_csr_op(csr_op), .i_csr_addr(csr_addr),
    .i_csr_wdata(csr_wdata), .o_csr_ready(csr_ready), .o_csr_rdata(csr_rdata),
    .o_illegal_csr(illegal), .i_pc(pc), .i_instr_retire(retire),
    .i_exc_valid(exc_valid), .i_exc_cause(exc_cause), .i_mret(mret),
    .i_mtimer_intr(timer), .i_mextern_intr(ext), .i_msoftware_intr(sw),
    .o_busy(busy), .o_redirect(redirect), .o_redirect_pc(redirect_pc),
    .o_trap_taken(trap_taken), .o_mstatus(mstatus), .o_mie(mie), .o_mip(mip),
    .o_mepc(mepc), .o_mcause(mcause), .o_mscratch(mscratch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic wait_ready(input int exp_lat, input string name);
    int lat;
    csr_exp_t e;
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (csr_ready) begin lat = c; break; end
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s ack_latency got=%0d want=%0d", name, lat, exp_lat);
    end
    e = csr_q.pop_front();
    checks++;
    if ({illegal, csr_rdata} !== {e.ill, e.rdata}) begin
      failures++;
      $display("FAIL %s ill/rdata got=%b/%h want=%b/%h", name, illegal, csr_rdata, e.ill, e.rdata);
    end
    @(posedge clk); #1;
    csr_valid = 1'b0;
  endtask

  task automatic csr_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_ill, input string name);
    csr_q.push_back({exp_ill, exp_rd});
    csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    wait_ready(1, name);
  endtask

  task automatic wait_redirect(input int exp_lat, input string name);
    int lat;
    rd_exp_t e;
    lat = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (redirect) begin lat = c; break; end
      if (c == 0) begin
        @(posedge clk); #1;
        exc_valid = 1'b0; mret = 1'b0; retire = 1'b0;
      end
    end
    exc_valid = 1'b0; mret = 1'b0; retire = 1'b0;
    checks++;
    if (lat != exp_lat || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s redirect_latency got=%0d busy=%b want=%0d busy=1", name, lat, busy, exp_lat);
    end
    e = rd_q.pop_front();
    checks++;
    if ({trap_taken, redirect_pc} !== {e.trap, e.pc}) begin
      failures++;
      $display("FAIL %s trap/pc got=%b/%h want=%b/%h", name, trap_taken, redirect_pc, e.trap, e.pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, csr_ready, illegal, redirect, trap_taken, csr_rdata, redirect_pc,
         mstatus, mie, mip, mscratch, mepc, mcause} !==
        {5'b0, 32'h0, 32'h0, 32'h0000_1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_values mstatus=%h mie=%h mip=%h busy=%b redirect=%b want mstatus=00001800 rest 0",
               mstatus, mie, mip, busy, redirect);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ro_reads();
    csr_access(2'b10, 12'h300, 32'h0, 32'h0000_1800, 1'b0, "read_mstatus");
    csr_access(2'b10, 12'h301, 32'h0, 32'h4000_0100, 1'b0, "read_misa");
    csr_access(2'b11, 12'h305, 32'h0, MTVEC,          1'b0, "read_mtvec");
    csr_access(2'b10, 12'hF14, 32'h0, 32'h0,          1'b0, "read_mhartid");
  endtask

  task automatic test_mscratch();
    csr_access(2'b01, 12'h340, 32'hDEAD_BEEF, 32'h0, 1'b0, "rw_mscratch");
    csr_access(2'b10, 12'h340, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "rs_mscratch");
    checks++;
    if (mscratch !== 32'hDEAD_BEFF) begin
      failures++; $display("FAIL mscratch_after_rs got=%h want=deadbeff", mscratch);
    end
    csr_access(2'b11, 12'h340, 32'hFFFF_0000, 32'hDEAD_BEFF, 1'b0, "rc_mscratch");
    checks++;
    if (mscratch !== 32'h0000_BEFF) begin
      failures++; $display("FAIL mscratch_after_rc got=%h want=0000beff", mscratch);
    end
  endtask

  task automatic test_field_masks();
    csr_access(2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0, "rw_mstatus_ones");
    checks++;
    if (mstatus !== 32'h0000_1888) begin
      failures++; $display("FAIL mstatus_mask got=%h want=00001888", mstatus);
    end
    csr_access(2'b01, 12'h300, 32'h0, 32'h0000_1888, 1'b0, "rw_mstatus_zero");
    csr_access(2'b01, 12'h342, 32'hFFFF_FFFF, 32'h0, 1'b0, "rw_mcause_ones");
    csr_access(2'b01, 12'h341, 32'h0000_0123, 32'h0, 1'b0, "rw_mepc");
    csr_access(2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0, 1'b0, "rw_mie_ones");
    checks++;
    if ({mstatus, mcause, mepc, mie} !== {32'h0000_1800, 32'h8000_000F, 32'h0000_0120, 32'h0000_0888}) begin
      failures++;
      $display("FAIL field_masks got mstatus=%h mcause=%h mepc=%h mie=%h want 00001800 8000000f 00000120 00000888",
               mstatus, mcause, mepc, mie);
    end
    csr_access(2'b01, 12'h304, 32'h0, 32'h0000_0888, 1'b0, "rw_mie_zero");
  endtask

  task automatic test_illegal();
    csr_access(2'b01, 12'h301, 32'h0000_1234, 32'h4000_0100, 1'b1, "ill_rw_misa");
    csr_access(2'b10, 12'h7C0, 32'h0000_0005, 32'h0,          1'b1, "ill_unlisted");
    csr_access(2'b11, 12'h344, 32'h0000_0080, 32'h0,          1'b1, "ill_rc_mip");
    csr_access(2'b01, 12'h344, 32'h0,         32'h0,          1'b1, "ill_rw_mip_zero");
    checks++;
    if ({mscratch, mstatus, mie} !== {32'h0000_BEFF, 32'h0000_1800, 32'h0}) begin
      failures++;
      $display("FAIL illegal_no_change got mscratch=%h mstatus=%h mie=%h", mscratch, mstatus, mie);
    end
  endtask

  task automatic test_timer_intr();
    csr_access(2'b01, 12'h304, 32'h0000_0080, 32'h0, 1'b0, "set_mie_timer");
    csr_access(2'b10, 12'h300, 32'h0000_0008, 32'h0000_1800, 1'b0, "set_mstatus_mie");
    pc = 32'h100; timer = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (mip !== 32'h80 || busy !== 1'b0) begin
      failures++; $display("FAIL timer_mip got=%h busy=%b want=00000080 busy=0", mip, busy);
    end
    rd_q.push_back({1'b1, MTVEC});
    retire = 1'b1;
    wait_redirect(2, "timer_trap");
    checks++;
    if ({mcause, mepc, mstatus} !== {32'h8000_0007, 32'h0000_0100, 32'h0000_1880}) begin
      failures++;
      $display("FAIL timer_regs got mcause=%h mepc=%h mstatus=%h want 80000007 00000100 00001880",
               mcause, mepc, mstatus);
    end
    timer = 1'b0;
  endtask

  task automatic test_exc_vs_intr();
    csr_access(2'b01, 12'h304, 32'h0000_0800, 32'h0000_0080, 1'b0, "set_mie_ext");
    csr_access(2'b10, 12'h300, 32'h0000_0008, 32'h0000_1880, 1'b0, "reenable_mie");
    ext = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    pc = 32'h204;
    rd_q.push_back({1'b1, MTVEC});
    exc_valid = 1'b1; exc_cause = 4'd2; retire = 1'b1;
    wait_redirect(2, "exc_wins");
    checks++;
    if ({mcause, mepc, mstatus} !== {32'h0000_0002, 32'h0000_0204, 32'h0000_1880}) begin
      failures++;
      $display("FAIL exc_regs got mcause=%h mepc=%h mstatus=%h want 00000002 00000204 00001880",
               mcause, mepc, mstatus);
    end
    rd_q.push_back({1'b0, 32'h0000_0204});
    mret = 1'b1;
    wait_redirect(1, "mret");
    checks++;
    if (mstatus !== 32'h0000_1888) begin
      failures++; $display("FAIL mret_mstatus got=%h want=00001888", mstatus);
    end
    pc = 32'h208;
    rd_q.push_back({1'b1, MTVEC});
    retire = 1'b1;
    wait_redirect(2, "ext_after_mret");
    checks++;
    if ({mcause, mepc, mstatus} !== {32'h8000_000B, 32'h0000_0208, 32'h0000_1880}) begin
      failures++;
      $display("FAIL ext_regs got mcause=%h mepc=%h mstatus=%h want 8000000b 00000208 00001880",
               mcause, mepc, mstatus);
    end
    ext = 1'b0;
  endtask

  task automatic test_back_to_back();
    // exception beats a simultaneous CSR request; the held request is served right after
    pc = 32'h310;
    rd_q.push_back({1'b1, MTVEC});
    csr_q.push_back({1'b0, 32'h0000_BEFF});
    csr_valid = 1'b1; csr_op = 2'b10; csr_addr = 12'h340; csr_wdata = 32'h0;
    exc_valid = 1'b1; exc_cause = 4'd5;
    checks++;
    #1;
    if (csr_ready !== 1'b0) begin
      failures++; $display("FAIL csr_not_acked_on_loss got=%b want=0", csr_ready);
    end
    wait_redirect(2, "exc_over_csr");
    wait_ready(1, "held_csr");
    checks++;
    if ({mcause, mepc, mstatus} !== {32'h0000_0005, 32'h0000_0310, 32'h0000_1800}) begin
      failures++;
      $display("FAIL b2b_regs got mcause=%h mepc=%h mstatus=%h want 00000005 00000310 00001800",
               mcause, mepc, mstatus);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_redirect;
    saw_redirect = 1'b0;
    pc = 32'h400;
    exc_valid = 1'b1; exc_cause = 4'd4;
    @(negedge clk);
    @(posedge clk); #1;
    exc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL busy_in_trap_save got=%b want=1", busy);
    end
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_redirect = saw_redirect | redirect;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      saw_redirect = saw_redirect | redirect;
    end
    checks++;
    if (saw_redirect !== 1'b0) begin
      failures++; $display("FAIL reset_mid_redirect got=%b want=0", saw_redirect);
    end
    checks++;
    if ({busy, csr_ready, illegal, redirect, trap_taken, csr_rdata, redirect_pc,
         mstatus, mie, mip, mscratch, mepc, mcause} !==
        {5'b0, 32'h0, 32'h0, 32'h0000_1800, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_mid_values mstatus=%h mscratch=%h mepc=%h mcause=%h busy=%b want 00001800 0 0 0 0",
               mstatus, mscratch, mepc, mcause, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0; csr_valid = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
    pc = '0; retire = 1'b0; exc_valid = 1'b0; exc_cause = '0; mret = 1'b0;
    timer = 1'b0; ext = 1'b0; sw = 1'b0;
    test_reset();
    test_ro_reads();
    test_mscratch();
    test_field_masks();
    test_illegal();
    test_timer_intr();
    test_exc_vs_intr();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
